sys_array_dispatch: RTL and testbench
=====================================

Name: sys_array_dispatch

Overview:
- Consumer end of the split table produced by the matrix splitter.
- Once the splitter raises ready, it scans table entries [first_none, last) through a 1-cycle-latency read port and keeps only leaves (operation == connect_none).
- Issues one clear job over the root output window, then one MAC job per leaf, to the systolic-array controller through a valid/ready + done handshake.
- All leaves accumulate into a zeroed output, so connect_sum, connect_hor and connect_vert merges need no extra work.

Parameters:
- OUT_SIZE, 100, split-table depth; indices range 0..OUT_SIZE-1.
- IDX_W, 16, width of table indices and counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  pulse; begin a dispatch run
- split_ready  in  1  splitter table complete
- first_none  in  IDX_W  first leaf index from splitter
- last  in  IDX_W  one past the final valid table index
- tbl_rd_en  out  1  table read strobe
- tbl_idx  out  IDX_W  table read address
- tbl_entry  in  split_type  entry data, valid the cycle after tbl_rd_en
- job_valid  out  1  job offered
- job_ready  in  1  array accepts job
- job_op  out  job_op_t  JOB_CLEAR or JOB_MAC
- job_id  out  IDX_W  table index of the leaf (0 for clear)
- job_win  out  split_type  A/B/O windows of the job
- job_done  in  1  pulse; outstanding job finished
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- err  out  1  sticky; empty-range or bad-index run
- leaf_count  out  IDX_W  MAC jobs completed in current/last run

Behaviour:
- Reset: synchronous, active-low (reset_n), clock clk.
  - State returns to IDLE; all outputs go to 0, including job_win, err and leaf_count.
  - Reset mid-run drops job_valid immediately; a later job_done is ignored.
- IDLE:
  - Waits for start && split_ready; start without split_ready is ignored.
  - On start, latches first_none and last, clears err and leaf_count, sets busy.
  - If the latched last <= first_none or last > OUT_SIZE: set err, go to FINISH.
  - Otherwise read index 0 (tbl_rd_en=1, tbl_idx=0) and go to ROOT.
- ROOT: captures tbl_entry; job_win = entry, job_op = JOB_CLEAR; goes to ISSUE.
- ISSUE:
  - job_valid=1; job_op, job_id and job_win stay stable until job_valid && job_ready.
  - On that handshake, job_valid drops the next cycle and the block goes to WAIT.
- WAIT: on job_done, if the job was MAC, leaf_count += 1.
  - Then, if scan index cur < latched last: drive tbl_rd_en for cur and go to CHECK.
  - Otherwise go to FINISH.
  - The first scan read uses cur = latched first_none.
- CHECK: cur increments when tbl_entry is captured.
  - If entry.operation == connect_none: job_op=JOB_MAC, job_id=entry.n, job_win=entry; go to ISSUE.
  - Else, if cur < last: issue the next read in the same cycle (back-to-back, 1 entry/cycle) and stay in CHECK.
  - Else go to FINISH.
- FINISH: done=1 for one cycle, busy=0, go to IDLE.
- Only one job is outstanding at a time. job_done outside WAIT is ignored.
- Simultaneous job_ready and job_done in ISSUE: done is ignored; only the handshake counts.
- start while busy is ignored.
- Root-only split (root is a leaf, first_none=0, last=1): clear job, then one MAC with job_id 0.
- Counters wrap-free by construction (last <= OUT_SIZE < 2^IDX_W).

Optional Feature:
- Macro: SYS_ARRAY_DISPATCH_PERF_EN.
- Defined:
  - Adds output cycles (32 bit): counts clocks while busy, clears on start, holds after done.
  - Adds output stall (32 bit): counts cycles with job_valid && !job_ready.
- Undefined: neither port nor its counters exists; behaviour is otherwise identical.

Decomposition:
- Package sys_array_pkg holds:
  - operation_types and split_type, moved out of the `ifndef types guard;
  - new enum job_op_t {JOB_CLEAR, JOB_MAC};
  - state enum dispatch_state_t {IDLE, ROOT, ISSUE, WAIT, CHECK, FINISH}.
- One natural sub-module, sys_array_leaf_scan: owns cur, the read port and the connect_none filter, and presents the next leaf with a valid/ready handshake to the dispatcher FSM.

Test Plan:
- Single leaf (root is the only entry): first_none=0, last=1, root op=connect_none, O window 0..3 x 0..3 -> clear job with root windows, then MAC job_id=0, leaf_count=1, done pulse, err=0.
- Vertical split: entries 0=vert, 1 and 2 leaves, first_none=1, last=3 -> jobs CLEAR, MAC id1, MAC id2 in order; leaf_count=2.
- Mixed table (internal node at index 3 amid leaves), first_none=1, last=7 -> index 3 skipped, MAC jobs ids 1,2,4,5,6; scan reads back-to-back.
- Backpressure: job_ready held low 5 cycles on the second job -> job fields stable for all 5 cycles, exactly one handshake; with PERF_EN, stall=5.
- Error range: last=2, first_none=2 -> no jobs issued, err=1, done pulse, leaf_count=0.
- Reset mid-WAIT after 2 MACs, then job_done pulse -> busy=0, leaf_count=0, pulse ignored; a new start reruns from the clear job.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Shared types for the split-table dispatcher: split table entries, job opcodes and FSM states.
package sys_array_pkg;

  localparam int unsigned SA_OUT_SIZE = 100;
  localparam int unsigned SA_IDX_W    = 16;

  typedef enum logic [1:0] {
    connect_none,
    connect_sum,
    connect_hor,
    connect_vert
  } operation_types;

  typedef struct packed {
    logic [SA_IDX_W-1:0] row_lo;
    logic [SA_IDX_W-1:0] row_hi;
    logic [SA_IDX_W-1:0] col_lo;
    logic [SA_IDX_W-1:0] col_hi;
  } window_t;

  typedef struct packed {
    operation_types      operation;
    logic [SA_IDX_W-1:0] n;
    window_t             a;
    window_t             b;
    window_t             o;
  } split_type;

  typedef enum logic {
    JOB_CLEAR,
    JOB_MAC
  } job_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ROOT,
    ISSUE,
    WAIT,
    CHECK,
    FINISH
  } dispatch_state_t;

  // Leaves carry real work; every other operation is a merge node.
  function automatic logic is_leaf(input split_type e);
    return e.operation == connect_none;
  endfunction

endpackage

// File: rtl/sys_array_leaf_scan.sv
// Owns the split-table read port: fetches the root entry and streams the table
// looking for the next leaf, reading one entry per cycle speculatively.
module sys_array_leaf_scan
  import sys_array_pkg::*;
#(
  parameter int unsigned IDX_W = SA_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [IDX_W-1:0] first_none,
  input  logic [IDX_W-1:0] last,
  input  logic             root_req,
  input  logic             next_req,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  split_type        tbl_entry,
  output logic             root_valid,
  output logic             leaf_valid,
  output logic             scan_end,
  output split_type        entry_q
);

  logic [IDX_W-1:0] cur;
  logic [IDX_W-1:0] rd_ptr;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] cur_inc;
  logic             scanning;
  logic             root_mode;
  logic             pend;
  logic             can_read;

  assign cur_inc  = cur + 1'b1;
  assign can_read = rd_ptr < last_q;

  // cur tracks the entry being captured, rd_ptr runs ahead by the read latency.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur        <= '0;
      rd_ptr     <= '0;
      last_q     <= '0;
      scanning   <= 1'b0;
      root_mode  <= 1'b0;
      pend       <= 1'b0;
      tbl_rd_en  <= 1'b0;
      tbl_idx    <= '0;
      root_valid <= 1'b0;
      leaf_valid <= 1'b0;
      scan_end   <= 1'b0;
      entry_q    <= '0;
    end else begin
      tbl_rd_en  <= 1'b0;
      root_valid <= 1'b0;
      leaf_valid <= 1'b0;
      scan_end   <= 1'b0;
      pend       <= tbl_rd_en;
      if (load) begin
        cur      <= first_none;
        rd_ptr   <= first_none;
        last_q   <= last;
        scanning <= 1'b0;
      end
      if (root_req) begin
        tbl_rd_en <= 1'b1;
        tbl_idx   <= '0;
        root_mode <= 1'b1;
      end else if (root_mode) begin
        if (pend) begin
          root_valid <= 1'b1;
          entry_q    <= tbl_entry;
          root_mode  <= 1'b0;
        end
      end else if (next_req) begin
        if (cur < last_q) begin
          scanning  <= 1'b1;
          tbl_rd_en <= 1'b1;
          tbl_idx   <= rd_ptr;
          rd_ptr    <= rd_ptr + 1'b1;
        end else begin
          scan_end <= 1'b1;
        end
      end else if (scanning) begin
        if (pend) begin
          cur <= cur_inc;
          if (is_leaf(tbl_entry)) begin
            // Rewind past any speculative read and drop its returning data.
            leaf_valid <= 1'b1;
            entry_q    <= tbl_entry;
            scanning   <= 1'b0;
            rd_ptr     <= cur_inc;
            pend       <= 1'b0;
          end else if (cur_inc >= last_q) begin
            scan_end <= 1'b1;
            scanning <= 1'b0;
            pend     <= 1'b0;
          end else if (can_read) begin
            tbl_rd_en <= 1'b1;
            tbl_idx   <= rd_ptr;
            rd_ptr    <= rd_ptr + 1'b1;
          end
        end else if (can_read) begin
          tbl_rd_en <= 1'b1;
          tbl_idx   <= rd_ptr;
          rd_ptr    <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sys_array_dispatch.sv
// Dispatches one clear job then one MAC job per split-table leaf to the systolic array.
// Optional SYS_ARRAY_DISPATCH_PERF_EN adds busy-cycle and stall counters.
module sys_array_dispatch
  import sys_array_pkg::*;
#(
  parameter int unsigned OUT_SIZE = SA_OUT_SIZE,
  parameter int unsigned IDX_W    = SA_IDX_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             split_ready,
  input  logic [IDX_W-1:0] first_none,
  input  logic [IDX_W-1:0] last,
  output logic             tbl_rd_en,
  output logic [IDX_W-1:0] tbl_idx,
  input  split_type        tbl_entry,
  output logic             job_valid,
  input  logic             job_ready,
  output job_op_t          job_op,
  output logic [IDX_W-1:0] job_id,
  output split_type        job_win,
  input  logic             job_done,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] leaf_count
`ifdef SYS_ARRAY_DISPATCH_PERF_EN
  ,
  output logic [31:0]      cycles,
  output logic [31:0]      stall
`endif
);

  dispatch_state_t state;
  logic            load_c;
  logic            range_ok_c;
  logic            next_req_c;
  logic            root_valid;
  logic            leaf_valid;
  logic            scan_end;
  split_type       entry_q;

  assign load_c     = (state == IDLE) && start && split_ready;
  assign range_ok_c = (last > first_none) && (32'(last) <= OUT_SIZE);
  assign next_req_c = (state == WAIT) && job_done;

  sys_array_leaf_scan #(
    .IDX_W(IDX_W)
  ) u_scan (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load_c),
    .first_none(first_none),
    .last      (last),
    .root_req  (load_c && range_ok_c),
    .next_req  (next_req_c),
    .tbl_rd_en (tbl_rd_en),
    .tbl_idx   (tbl_idx),
    .tbl_entry (tbl_entry),
    .root_valid(root_valid),
    .leaf_valid(leaf_valid),
    .scan_end  (scan_end),
    .entry_q   (entry_q)
  );

  // Dispatch FSM: one job outstanding at a time.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      job_valid  <= 1'b0;
      job_op     <= JOB_CLEAR;
      job_id     <= '0;
      job_win    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      leaf_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_c) begin
            busy       <= 1'b1;
            err        <= 1'b0;
            leaf_count <= '0;
            if (range_ok_c) begin
              state <= ROOT;
            end else begin
              err   <= 1'b1;
              state <= FINISH;
            end
          end
        end
        ROOT: begin
          if (root_valid) begin
            job_op    <= JOB_CLEAR;
            job_id    <= '0;
            job_win   <= entry_q;
            job_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (job_ready) begin
            job_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (job_done) begin
            if (job_op == JOB_MAC) leaf_count <= leaf_count + 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (leaf_valid) begin
            job_op    <= JOB_MAC;
            job_id    <= IDX_W'(entry_q.n);
            job_win   <= entry_q;
            job_valid <= 1'b1;
            state     <= ISSUE;
          end else if (scan_end) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYS_ARRAY_DISPATCH_PERF_EN
  // Both counters restart with each accepted run.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycles <= '0;
      stall  <= '0;
    end else if (load_c) begin
      cycles <= '0;
      stall  <= '0;
    end else begin
      if (busy) cycles <= cycles + 1'b1;
      if (job_valid && !job_ready) stall <= stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sys_array_dispatch.sv
// Self-checking bench: table memory and array responder driven against a job-list reference model.
module tb_sys_array_dispatch;
  import sys_array_pkg::*;

  localparam int unsigned IW = SA_IDX_W;
  localparam int unsigned NT = SA_OUT_SIZE;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          split_ready;
  logic [IW-1:0] first_none;
  logic [IW-1:0] last;
  logic          tbl_rd_en;
  logic [IW-1:0] tbl_idx;
  split_type     tbl_entry;
  logic          job_valid;
  logic          job_ready;
  job_op_t       job_op;
  logic [IW-1:0] job_id;
  split_type     job_win;
  logic          job_done;
  logic          busy;
  logic          done;
  logic          err;
  logic [IW-1:0] leaf_count;
`ifdef SYS_ARRAY_DISPATCH_PERF_EN
  logic [31:0]   cycles;
  logic [31:0]   stall;
`endif

  sys_array_dispatch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .split_ready(split_ready),
    .first_none (first_none),
    .last       (last),
    .tbl_rd_en  (tbl_rd_en),
    .tbl_idx    (tbl_idx),
    .tbl_entry  (tbl_entry),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_op     (job_op),
    .job_id     (job_id),
    .job_win    (job_win),
    .job_done   (job_done),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .leaf_count (leaf_count)
`ifdef SYS_ARRAY_DISPATCH_PERF_EN
    ,
    .cycles     (cycles),
    .stall      (stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    job_op_t       op;
    logic [IW-1:0] id;
    split_type     win;
  } job_t;

  split_type tbl [NT];
  job_t      exp_q[$];
  int        n_assert = 0;
  int        n_fail   = 0;
  int        pcount   = 0;
  int        b2b_cnt  = 0;
  int        bad_reads = 0;
  int        win_first = 0;
  int        win_last  = 0;
  logic      rd_prev  = 1'b0;

  // Table read port: data the cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    if (tbl_rd_en) tbl_entry <= (int'(tbl_idx) < NT) ? tbl[int'(tbl_idx)] : '1;
    else           tbl_entry <= '1;
  end

  always @(posedge clk) begin
    pcount  <= pcount + 1;
    rd_prev <= tbl_rd_en;
    if (tbl_rd_en && rd_prev) b2b_cnt <= b2b_cnt + 1;
    if (tbl_rd_en && tbl_idx != 0 && (int'(tbl_idx) < win_first || int'(tbl_idx) >= win_last))
      bad_reads <= bad_reads + 1;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic split_type mk(input operation_types op, input int n,
                                   input int r0, input int r1, input int c0, input int c1);
    split_type e;
    e = '0;
    e.operation = op;
    e.n = IW'(n);
    e.a = '{IW'(r0), IW'(r1), IW'(0), IW'(c1)};
    e.b = '{IW'(0), IW'(c1), IW'(c0), IW'(c1)};
    e.o = '{IW'(r0), IW'(r1), IW'(c0), IW'(c1)};
    return e;
  endfunction

  task automatic fill_nonleaf();
    for (int i = 0; i < NT; i++) tbl[i] = mk(connect_sum, i, i, i + 1, 0, 7);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NT; i++) begin
      tbl[i].operation = ($urandom_range(0, 1) == 1) ? connect_none
                                                     : operation_types'($urandom_range(1, 3));
      tbl[i].n = IW'(i);
      tbl[i].a = window_t'({$urandom, $urandom});
      tbl[i].b = window_t'({$urandom, $urandom});
      tbl[i].o = window_t'({$urandom, $urandom});
    end
  endtask

  // Reference: clear over root, then every leaf in [first, last) in index order.
  task automatic build_expected(input int first, input int lst, output bit bad, output int macs);
    job_t j;
    exp_q.delete();
    macs = 0;
    bad = !(lst > first && lst <= NT);
    if (!bad) begin
      j.op = JOB_CLEAR; j.id = '0; j.win = tbl[0];
      exp_q.push_back(j);
      for (int i = first; i < lst; i++) begin
        if (tbl[i].operation == connect_none) begin
          j.op = JOB_MAC; j.id = tbl[i].n; j.win = tbl[i];
          exp_q.push_back(j);
          macs++;
        end
      end
    end
  endtask

  task automatic do_run(input int first, input int lst, input int stall_job, input int stall_n,
                        input bit done_with_ready, input int stop_after, output int b2b);
    bit   bad, fin, aborted;
    int   macs_exp, macs, seen, gap, b2b0, bad0, pc_start, pc_done;
    job_t e;
    build_expected(first, lst, bad, macs_exp);
    win_first = first;
    win_last  = lst;
    b2b0 = b2b_cnt;
    bad0 = bad_reads;
    @(negedge clk);
    first_none = IW'(first); last = IW'(lst); start = 1'b1; split_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pc_start = pcount;
    chk("busy_after_start", busy, 1);
    seen = 0; macs = 0; fin = 0; aborted = 0; pc_done = 0;
    for (int cyc = 0; cyc < 3000 && !fin && !aborted; cyc++) begin
      if (done) begin
        fin = 1;
        pc_done = pcount;
      end else if (job_valid) begin
        if (seen >= exp_q.size()) begin
          chk("job_count_overrun", seen + 1, exp_q.size());
          fin = 1;
        end else begin
          e = exp_q[seen];
          chk("job_op", job_op, e.op);
          chk("job_id", job_id, e.id);
          chk("job_win", job_win, e.win);
          chk("leaf_count_live", leaf_count, macs);
          if (seen == stall_job) begin
            for (int k = 0; k < stall_n; k++) begin
              @(negedge clk);
              chk("stall_valid", job_valid, 1);
              chk("stall_fields", {job_op, job_id, job_win}, {e.op, e.id, e.win});
            end
          end
          job_ready = 1'b1;
          if (seen == stall_job && done_with_ready) job_done = 1'b1;
          @(negedge clk);
          job_ready = 1'b0;
          job_done  = 1'b0;
          chk("valid_drop", job_valid, 0);
          if (e.op == JOB_MAC) macs++;
          seen++;
          if (seen == stop_after) begin
            aborted = 1;
          end else begin
            gap = $urandom_range(0, 3);
            for (int k = 0; k < gap; k++) begin
              chk("no_job_while_wait", job_valid, 0);
              @(negedge clk);
            end
            job_done = 1'b1;
            @(negedge clk);
            job_done = 1'b0;
          end
        end
      end else begin
        @(negedge clk);
      end
    end
    if (!aborted) chk("run_timeout", fin, 1);
    if (fin) begin
      chk("done_busy", busy, 0);
      chk("jobs_issued", seen, exp_q.size());
      chk("leaf_count", leaf_count, macs_exp);
      chk("err", err, bad);
`ifdef SYS_ARRAY_DISPATCH_PERF_EN
      chk("stall_cnt", stall, (stall_job >= 0 && stall_job < exp_q.size()) ? stall_n : 0);
      chk("cycles_cnt", cycles, pc_done - pc_start + 1);
`endif
      @(negedge clk);
      chk("done_pulse_width", done, 0);
`ifdef SYS_ARRAY_DISPATCH_PERF_EN
      chk("cycles_hold", cycles, pc_done - pc_start + 1);
`endif
    end
    chk("reads_in_range", bad_reads - bad0, 0);
    b2b = b2b_cnt - b2b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b2b, first, lst;
    reset_n = 1'b0; start = 1'b0; split_ready = 1'b0; first_none = '0; last = '0;
    job_ready = 1'b0; job_done = 1'b0;
    fill_nonleaf();
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_leaf_count", leaf_count, 0);
    chk("rst_job_valid", job_valid, 0);
    chk("rst_job_fields", {job_op, job_id, job_win}, 0);
    chk("rst_rd_en", tbl_rd_en, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // start without split_ready is ignored
    first_none = IW'(0); last = IW'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("start_no_ready_busy", busy, 0);
    chk("start_no_ready_rd", tbl_rd_en, 0);

    // single leaf: root is the only entry
    tbl[0] = mk(connect_none, 0, 0, 3, 0, 3);
    do_run(0, 1, -1, 0, 0, -1, b2b);

    // vertical split
    fill_nonleaf();
    tbl[0] = mk(connect_vert, 0, 0, 7, 0, 7);
    tbl[1] = mk(connect_none, 1, 0, 7, 0, 3);
    tbl[2] = mk(connect_none, 2, 0, 7, 4, 7);
    do_run(1, 3, -1, 0, 0, -1, b2b);

    // mixed table with an internal node at 3; stall the second job 5 cycles
    fill_nonleaf();
    tbl[0] = mk(connect_hor, 0, 0, 15, 0, 15);
    tbl[1] = mk(connect_none, 1, 0, 3, 0, 15);
    tbl[2] = mk(connect_none, 2, 4, 7, 0, 15);
    tbl[3] = mk(connect_sum, 3, 8, 15, 0, 15);
    tbl[4] = mk(connect_none, 4, 8, 11, 0, 15);
    tbl[5] = mk(connect_none, 5, 12, 15, 0, 7);
    tbl[6] = mk(connect_none, 6, 12, 15, 8, 15);
    do_run(1, 7, 1, 5, 1, -1, b2b);
    chk("b2b_reads_seen", b2b > 0, 1);

    // empty range and out-of-table range
    do_run(2, 2, -1, 0, 0, -1, b2b);
    do_run(5, NT + 1, -1, 0, 0, -1, b2b);

    // reset while waiting on the fourth job (after 2 MACs completed)
    do_run(1, 7, -1, 0, 0, 4, b2b);
    chk("pre_reset_leaf_count", leaf_count, 2);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_leaf_count", leaf_count, 0);
    chk("mid_reset_job_valid", job_valid, 0);
    reset_n = 1'b1;
    job_done = 1'b1;
    @(negedge clk);
    job_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_reset_busy", busy, 0);
    chk("post_reset_leaf_count", leaf_count, 0);
    chk("post_reset_job_valid", job_valid, 0);
    do_run(1, 7, -1, 0, 0, -1, b2b);

    // randomized tables, ranges, stalls
    for (int r = 0; r < 15; r++) begin
      fill_random();
      first = $urandom_range(0, NT - 1);
      if (r % 5 == 4) lst = $urandom_range(0, NT + 2);
      else            lst = first + $urandom_range(1, (NT - first < 12) ? NT - first : 12);
      do_run(first, lst, $urandom_range(0, 3), $urandom_range(0, 4),
             1'($urandom_range(0, 1)), -1, b2b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
